// File: rtl/multi_segment_scan_if.sv
// Load handshake and display-pin bundle for multi_segment_scan.
// valid/ready: a transfer happens on any rising edge where load_valid && load_ready; the source holds data until then.
interface multi_segment_scan_if #(
    parameter int DIGITS = 4
);
    logic                  load_valid;
    logic                  load_ready;
    logic [4*DIGITS-1:0]   load_value;
    logic [DIGITS-1:0]     load_dp;
    logic [7:0]            display_out;
    logic [DIGITS-1:0]     dig_en;
    logic                  frame_done;

    modport slave (
        input  load_valid, load_value, load_dp,
        output load_ready, display_out, dig_en, frame_done
    );

    modport master (
        output load_valid, load_value, load_dp,
        input  load_ready, display_out, dig_en, frame_done
    );
endinterface

// File: rtl/multi_segment_scan.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous shadow loading.
// Optional macro MULTI_SEGMENT_LZB_EN enables leading-zero blanking.
module multi_segment_scan #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 5000,
    parameter int BLANK_CYC = 50
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    multi_segment_scan_if.slave  bus,
    output logic                 o_dbg_state
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DRIVE = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_active_val;
    logic [4*DIGITS-1:0] r_shadow_val;
    logic [DIGITS-1:0]   r_active_dp;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic                r_pending;
    logic [7:0]          r_display;
    logic [DIGITS-1:0]   r_dig_en;
    logic                r_frame_done;
    logic                r_load_ready;

    logic                w_wrap;
    logic                w_boundary;
    logic                w_accept;
    logic                w_pending_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [IW-1:0]       w_idx_nxt;
    state_t              w_state_nxt;
    logic [3:0]          w_nib;
    logic [6:0]          w_seg;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h79;
        endcase
    endfunction

`ifdef MULTI_SEGMENT_LZB_EN
    logic [DIGITS-1:0] w_blank_mask;

    // Walk from the most significant digit down; blanking stops at the first non-zero nibble.
    always_comb begin
        logic w_zero_run;
        w_blank_mask = '0;
        w_zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_run      = w_zero_run && (r_active_val[4*i +: 4] == 4'd0);
            w_blank_mask[i] = w_zero_run;
        end
    end
`endif

    always_comb begin
        w_wrap        = (r_cnt == CNT_LAST);
        w_boundary    = w_wrap && (r_idx == IDX_LAST);
        w_cnt_nxt     = w_wrap ? '0 : r_cnt + 1'b1;
        w_idx_nxt     = r_idx;
        if (w_wrap) begin
            w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
        w_state_nxt   = (w_cnt_nxt >= CNT_DRIVE) ? ST_DRIVE : ST_BLANK;
        w_accept      = bus.load_valid && r_load_ready;
        // A load accepted on the boundary cycle survives the boundary and waits a frame.
        w_pending_nxt = (r_pending && !w_boundary) || w_accept;
        w_nib         = r_active_val[w_idx_nxt*4 +: 4];
        w_seg         = decode(w_nib);
`ifdef MULTI_SEGMENT_LZB_EN
        if (w_blank_mask[w_idx_nxt]) begin
            w_seg = '0;
        end
`endif
    end

    // Outputs are computed from next-cycle counters so segments and enables switch on one edge.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state      <= ST_BLANK;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_active_val <= '0;
            r_active_dp  <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_pending    <= 1'b0;
            r_display    <= '0;
            r_dig_en     <= '0;
            r_frame_done <= 1'b0;
            r_load_ready <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_pending    <= w_pending_nxt;
            r_load_ready <= !w_pending_nxt;
            r_frame_done <= (w_idx_nxt == IDX_LAST) && (w_cnt_nxt == CNT_LAST);
            if (w_accept) begin
                r_shadow_val <= bus.load_value;
                r_shadow_dp  <= bus.load_dp;
            end
            if (w_boundary && r_pending) begin
                r_active_val <= r_shadow_val;
                r_active_dp  <= r_shadow_dp;
            end
            if (w_state_nxt == ST_DRIVE) begin
                r_display <= {r_active_dp[w_idx_nxt], w_seg};
                r_dig_en  <= DIGITS'(1) << w_idx_nxt;
            end else begin
                r_display <= '0;
                r_dig_en  <= '0;
            end
        end
    end

    assign bus.load_ready  = r_load_ready;
    assign bus.display_out = r_display;
    assign bus.dig_en      = r_dig_en;
    assign bus.frame_done  = r_frame_done;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_multi_segment_scan.sv
// Directed bench for multi_segment_scan: expected glyphs are queued per load
// and checked slot by slot over the frame in which they should be shown.
module tb_multi_segment_scan;
    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 20;
    localparam int BLANK_CYC = 4;
    localparam int FRAME     = DIGITS * SCAN_DIV;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    logic dbg_state;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int n_accepts  = 0;
    int accept_cyc = -1;

    logic [7:0] exp_q[$];

    multi_segment_scan_if #(.DIGITS(DIGITS)) bus ();

    multi_segment_scan #(
        .DIGITS(DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .bus(bus),
        .o_dbg_state(dbg_state)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Handshake is judged just before the rising edge; valid drops on the following negedge.
    task automatic step();
        bit accepted_now;
        accepted_now = 1'b0;
        if (bus.load_valid && bus.load_ready) begin
            accepted_now = 1'b1;
            accept_cyc   = cyc;
        end
        @(negedge CLOCK);
        cyc++;
        if (accepted_now) begin
            bus.load_valid = 1'b0;
            n_accepts++;
        end
    endtask

    function automatic logic [7:0] glyph(input logic [15:0] val, input logic [3:0] dp, input int d);
        logic [3:0] nib;
        logic [6:0] seg;
        nib = val[4*d +: 4];
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            default: seg = 7'h79;
        endcase
`ifdef MULTI_SEGMENT_LZB_EN
        if (d >= 1 && (val >> (4*d)) == 16'd0) seg = 7'h00;
`endif
        return {dp[d], seg};
    endfunction

    task automatic push_exp(input logic [15:0] val, input logic [3:0] dp);
        for (int d = 0; d < DIGITS; d++) exp_q.push_back(glyph(val, dp, d));
    endtask

    task automatic do_load(input logic [15:0] val, input logic [3:0] dp, input bit push);
        int start;
        repeat ($urandom_range(1, 3)) step();
        start = n_accepts;
        bus.load_value = val;
        bus.load_dp    = dp;
        bus.load_valid = 1'b1;
        for (int n = 0; n < 300 && n_accepts == start; n++) step();
        chk("load_accepted", n_accepts - start, 1);
        if (push) push_exp(val, dp);
    endtask

    task automatic wait_boundary(output int bcyc);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            step();
            if (bus.frame_done === 1'b1) seen = 1'b1;
        end
        chk("boundary_seen", seen, 1);
        bcyc = cyc;
    endtask

    // Called on a boundary cycle; checks the whole following frame and ends on the next boundary.
    task automatic check_frame(input string name);
        logic [7:0] g[DIGITS];
        logic [3:0] en_exp;
        for (int d = 0; d < DIGITS; d++) begin
            if (exp_q.size() > 0) g[d] = exp_q.pop_front();
            else g[d] = 8'hxx;
        end
        for (int j = 0; j < FRAME; j++) begin
            int d;
            int k;
            d = j / SCAN_DIV;
            k = j % SCAN_DIV;
            step();
            if (k < BLANK_CYC) begin
                chk($sformatf("%s_blank_en_d%0d_k%0d", name, d, k), bus.dig_en, 0);
                chk($sformatf("%s_blank_seg_d%0d_k%0d", name, d, k), bus.display_out, 0);
                chk($sformatf("%s_blank_state_d%0d_k%0d", name, d, k), dbg_state, 0);
            end else begin
                en_exp = 4'b0001 << d;
                chk($sformatf("%s_drive_en_d%0d_k%0d", name, d, k), bus.dig_en, en_exp);
                chk($sformatf("%s_drive_seg_d%0d_k%0d", name, d, k), bus.display_out, g[d]);
                chk($sformatf("%s_drive_state_d%0d_k%0d", name, d, k), dbg_state, 1);
            end
            chk($sformatf("%s_frame_done_j%0d", name, j), bus.frame_done, (j == FRAME - 1) ? 1 : 0);
        end
    endtask

    initial begin
        int b1;
        int b2;
        int b3;
        int rise;
        bus.load_valid = 1'b0;
        bus.load_value = '0;
        bus.load_dp    = '0;

        // Reset state
        RESET = 1'b1;
        repeat (3) step();
        chk("rst_display", bus.display_out, 0);
        chk("rst_dig_en", bus.dig_en, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_load_ready", bus.load_ready, 0);
        chk("rst_state", dbg_state, 0);
        RESET = 1'b0;
        rise = 0;
        for (int n = 1; n <= 20 && rise == 0; n++) begin
            step();
            if (n == 1) chk("ready_after_reset", bus.load_ready, 1);
            if (bus.dig_en !== 4'b0000) rise = n;
        end
        chk("dig_en_rise_delay", rise, BLANK_CYC);
        chk("dig_en_first", bus.dig_en, 4'b0001);

        // Plain digits
        do_load(16'h1234, 4'b0000, 1'b1);
        wait_boundary(b1);
        check_frame("v1234");

        // Error glyphs, decimal point, zeros
        do_load(16'h00AF, 4'b0010, 1'b1);
        wait_boundary(b1);
        check_frame("v00af");

        // Back-to-back loads with the second held valid
        do_load(16'h1111, 4'b0000, 1'b1);
        chk("ready_drop_after_accept", bus.load_ready, 0);
        bus.load_value = 16'h2222;
        bus.load_dp    = 4'b0000;
        bus.load_valid = 1'b1;
        push_exp(16'h2222, 4'b0000);
        wait_boundary(b1);
        check_frame("v1111");
        chk("second_accept_cycle", accept_cyc, b1 + 1);
        check_frame("v2222");

        // Load accepted on the boundary cycle waits a full frame
        b3 = cyc;
        bus.load_value = 16'h5555;
        bus.load_dp    = 4'b1001;
        bus.load_valid = 1'b1;
        push_exp(16'h2222, 4'b0000);
        push_exp(16'h5555, 4'b1001);
        check_frame("v2222_hold");
        chk("boundary_accept_cycle", accept_cyc, b3);
        check_frame("v5555");

        // Free run frame period
        wait_boundary(b1);
        step();
        chk("frame_done_width", bus.frame_done, 0);
        wait_boundary(b2);
        chk("frame_period", b2 - b1, FRAME);
        chk("boundary_dig_en", bus.dig_en, 4'b1000);

        // Leading-zero pattern
        do_load(16'h0050, 4'b0000, 1'b1);
        wait_boundary(b1);
        check_frame("v0050");

        // Reset mid-drive with a pending load
        do_load(16'h8888, 4'b1111, 1'b0);
        rise = 0;
        for (int n = 0; n < 40 && rise == 0; n++) begin
            step();
            if (bus.dig_en !== 4'b0000) rise = 1;
        end
        chk("reached_drive", rise, 1);
        RESET = 1'b1;
        step();
        chk("midrst_display", bus.display_out, 0);
        chk("midrst_dig_en", bus.dig_en, 0);
        chk("midrst_load_ready", bus.load_ready, 0);
        RESET = 1'b0;
        step();
        chk("midrst_ready_after", bus.load_ready, 1);
        push_exp(16'h0000, 4'b0000);
        wait_boundary(b1);
        check_frame("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
